cpu_control_unit: RTL and testbench
===================================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 SHALL have parameter OPC_W, default 4, opcode width in bits.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, maximum wait cycles for mem_ack before a bus fault.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port opcode  input  OPC_W  upper field of the instruction register.
REQ-006 SHALL have port zero_flag  input  1  ALU zero flag, registered by the datapath.
REQ-007 SHALL have port carry_flag  input  1  ALU carry flag, registered by the datapath.
REQ-008 SHALL have port mem_ack  input  1  memory access complete.
REQ-009 SHALL have port mem_req  output  1  memory access request.
REQ-010 SHALL have port mem_we  output  1  write qualifier for mem_req; 0 means read.
REQ-011 SHALL have port pc_en  output  1  program counter increment strobe, one cycle.
REQ-012 SHALL have port pc_load  output  1  program counter load-from-operand strobe, one cycle.
REQ-013 SHALL have port ir_load  output  1  instruction register capture strobe.
REQ-014 SHALL have port acc_we  output  1  accumulator write enable.
REQ-015 SHALL have port alu_op  output  2  ALU operation: 00 pass, 01 add, 10 sub.
REQ-016 SHALL have port halted  output  1  core stopped.
REQ-017 SHALL have port fault  output  1  bus timeout occurred, sticky.

Function
REQ-018 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, PC_UPD and HALT, encoded in 3 bits.
REQ-019 SHALL, in FETCH, hold mem_req=1 and mem_we=0 until mem_ack; pulse ir_load in the ack cycle; then go to DECODE.
REQ-020 SHALL spend exactly one cycle in DECODE, latching opcode into an internal register.
REQ-021 SHALL decode opcodes as: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 JC, 15 HLT; all others SHALL execute as NOP.
REQ-022 SHALL, in EXEC, hold mem_req until mem_ack for LDA, ADD and SUB (read) and for STA (mem_we=1).
REQ-023 SHALL pulse acc_we in the ack cycle for LDA (alu_op=00), ADD (01) and SUB (10).
REQ-024 SHALL take one cycle in EXEC with no memory access for NOP, JMP, JZ and JC.
REQ-025 SHALL, in PC_UPD, assert pc_load for JMP, for JZ when zero_flag=1 and for JC when carry_flag=1; otherwise pc_en; never both; then go to FETCH.
REQ-026 SHALL sample the flags in PC_UPD, not in DECODE.
REQ-027 SHALL, on HLT in DECODE, enter HALT with pc_en=0 and halted=1, and remain there until reset.
REQ-028 SHALL count wait cycles while mem_req=1 and mem_ack=0; on reaching ACK_TIMEOUT it SHALL drop mem_req, set fault and enter HALT.
REQ-029 SHALL ignore mem_ack whenever mem_req=0.
REQ-030 SHALL give a non-jump instruction a latency of 4 cycles, FETCH to FETCH, with zero-wait memory.

Reset
REQ-031 SHALL, on reset_n low, immediately force state FETCH, clear the wait counter, and drive 0 on every output, with fault=0 and halted=0.
REQ-032 SHALL abort any in-flight access when reset is asserted mid-operation, with no strobe issued afterwards.
REQ-033 SHALL issue mem_req in the first rising edge after reset_n deasserts.

Configuration
REQ-034 SHALL support the macro CPU_CTRL_SINGLE_STEP_EN.
REQ-035 SHALL, with CPU_CTRL_SINGLE_STEP_EN defined, add input step (1 bit), hold in FETCH with mem_req=0 until step=1, and run exactly one instruction per step pulse.
REQ-036 SHALL, without CPU_CTRL_SINGLE_STEP_EN, have no step port and run freely.

Structure
REQ-037 SHALL place the state enum, opcode constants and alu_op encodings in shared package cpu_pkg.
REQ-038 SHALL isolate the access timeout counter in sub-module bus_timeout (inputs: clk, reset_n, busy, ack; output: expired).

Verification
REQ-039 SHALL verify zero-wait NOP: one pc_en per 4 cycles, and 3 pc_en over 12 cycles.
REQ-040 SHALL verify ADD with ack after 2 waits: mem_req is held 3 cycles, then acc_we=1 with alu_op=01 for 1 cycle, then pc_en.
REQ-041 SHALL verify JZ: with zero_flag=1, pc_load=1 and pc_en=0; with zero_flag=0, pc_en=1 and pc_load=0.
REQ-042 SHALL verify that mem_ack never arriving causes fault=1 and halted=1 after 15 wait cycles, with mem_req=0 thereafter.
REQ-043 SHALL verify that asserting reset_n=0 mid-STA wait drops all outputs to 0 in the same cycle, and that FETCH restarts after release.
REQ-044 SHALL verify that HLT (opcode 15) gives halted=1 with no further mem_req over 20 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, opcode values and ALU operation codes
package cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, PC_UPD, HALT} state_t;
  localparam int OP_NOP = 0;
  localparam int OP_LDA = 1;
  localparam int OP_STA = 2;
  localparam int OP_ADD = 3;
  localparam int OP_SUB = 4;
  localparam int OP_JMP = 5;
  localparam int OP_JZ  = 6;
  localparam int OP_JC  = 7;
  localparam int OP_HLT = 15;
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
endpackage

// File: rtl/bus_timeout.sv
// bus_timeout: counts consecutive busy cycles without ack; expired marks the LIMIT-th such cycle
module bus_timeout #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy,
  input  logic ack,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  assign expired = busy && !ack && cnt == CW'(LIMIT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (busy && !ack && !expired) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multicycle FETCH/DECODE/EXEC/PC_UPD sequencer with memory ack timeout
// Define CPU_CTRL_SINGLE_STEP_EN to add a step input that gates each instruction fetch
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_en,
  output logic             pc_load,
  output logic             ir_load,
  output logic             acc_we,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             fault
);
  state_t state;
  logic [OPC_W-1:0] op_q;
  logic expired, go, free, ack, is_mem, take;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  assign go   = step;
  assign free = 1'b0;
`else
  assign go   = 1'b1;
  assign free = 1'b1;
`endif
  assign ack = mem_req && mem_ack;
  assign is_mem = opcode == OPC_W'(OP_LDA) || opcode == OPC_W'(OP_STA) ||
                  opcode == OPC_W'(OP_ADD) || opcode == OPC_W'(OP_SUB);
  // flags are read live in PC_UPD so a flag update during EXEC is honoured
  assign take = op_q == OPC_W'(OP_JMP) || (op_q == OPC_W'(OP_JZ) && zero_flag) ||
                (op_q == OPC_W'(OP_JC) && carry_flag);
  assign ir_load = state == FETCH && ack;
  assign acc_we  = state == EXEC && ack && !mem_we;
  assign pc_load = state == PC_UPD && take;
  assign pc_en   = state == PC_UPD && !take;
  assign halted  = state == HALT;
  bus_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
    .clk(clk),
    .reset_n(reset_n),
    .busy(mem_req),
    .ack(mem_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= FETCH;
      op_q    <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      alu_op  <= ALU_PASS;
      fault   <= 1'b0;
    end else if (expired) begin
      state   <= HALT;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      alu_op  <= ALU_PASS;
      fault   <= 1'b1;
    end else begin
      case (state)
        FETCH:
          if (ack) begin
            state   <= DECODE;
            mem_req <= 1'b0;
          end else if (!mem_req && go) mem_req <= 1'b1;
        DECODE: begin
          op_q    <= opcode;
          state   <= opcode == OPC_W'(OP_HLT) ? HALT : EXEC;
          mem_req <= is_mem;
          mem_we  <= opcode == OPC_W'(OP_STA);
          alu_op  <= opcode == OPC_W'(OP_ADD) ? ALU_ADD :
                     opcode == OPC_W'(OP_SUB) ? ALU_SUB : ALU_PASS;
        end
        EXEC:
          if (!mem_req || mem_ack) begin
            state   <= PC_UPD;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            alu_op  <= ALU_PASS;
          end
        PC_UPD: begin
          state   <= FETCH;
          mem_req <= free;
        end
        default: state <= HALT;
      endcase
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: random instruction stream against a per-phase behavioural model
module tb_cpu_control_unit;
  localparam int TO = 15;
  logic clk = 1'b0, reset_n = 1'b0, zero_flag = 1'b0, carry_flag = 1'b0, mem_ack = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic mem_req, mem_we, pc_en, pc_load, ir_load, acc_we, halted, fault;
  logic [1:0] alu_op;
  int n_chk = 0, n_pass = 0, cyc = 0, npce = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (pc_en) npce++;
  cpu_control_unit #(.OPC_W(4), .ACK_TIMEOUT(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .opcode(opcode),
    .zero_flag(zero_flag),
    .carry_flag(carry_flag),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .pc_en(pc_en),
    .pc_load(pc_load),
    .ir_load(ir_load),
    .acc_we(acc_we),
    .alu_op(alu_op),
    .halted(halted),
    .fault(fault)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // {mem_req, mem_we, ir_load, acc_we, pc_en, pc_load, halted, fault}
  function automatic logic [7:0] outs();
    return {mem_req, mem_we, ir_load, acc_we, pc_en, pc_load, halted, fault};
  endfunction
  task automatic step_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, 32'(outs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  task automatic mem_phase(input string tag, input bit we, input bit fetch, input logic [1:0] aop,
                           input int waits, output bit to);
    to = 1'b0;
    for (int i = 0; i < waits && i < TO; i++) begin
      mem_ack = 1'b0;
      step_chk({tag, "_wait"}, {1'b1, we, 6'b0});
    end
    if (waits >= TO) begin
      to = 1'b1;
      mem_ack = 1'($urandom);
      step_chk({tag, "_timeout"}, 8'b0000_0011);
    end else begin
      mem_ack = 1'b1;
      @(negedge clk);
      chk({tag, "_ack"}, 32'(outs()), 32'({1'b1, we, fetch, !fetch && !we, 4'b0}));
      if (!fetch && !we) chk({tag, "_alu_op"}, 32'(alu_op), 32'(aop));
      @(posedge clk);
      #1;
      mem_ack = 1'($urandom);
    end
  endtask
  task automatic halt_hold(input string tag, input bit flt);
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom);
      step_chk(tag, {6'b0, 1'b1, flt});
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    mem_ack = 1'($urandom);
    step_chk("in_reset", 8'h00);
    step_chk("in_reset", 8'h00);
    reset_n = 1'b1;
    mem_ack = 1'($urandom);
    step_chk("post_reset", 8'h00);
  endtask
  task automatic run_instr(input int op, input int fw, input int ew, input int zf, input int cf);
    bit to, take, mem, st;
    logic [1:0] aop;
    opcode = 4'(op);
    mem_phase("fetch", 1'b0, 1'b1, 2'b00, fw, to);
    if (to) begin
      halt_hold("fault_halt", 1'b1);
      do_reset();
      return;
    end
    zero_flag = 1'($urandom);
    carry_flag = 1'($urandom);
    step_chk("decode", 8'h00);
    opcode = 4'($urandom);
    if (op == 15) begin
      halt_hold("hlt_halt", 1'b0);
      do_reset();
      return;
    end
    mem = op >= 1 && op <= 4;
    st = op == 2;
    aop = op == 3 ? 2'b01 : op == 4 ? 2'b10 : 2'b00;
    if (mem) begin
      mem_phase("exec", st, 1'b0, aop, ew, to);
      if (to) begin
        halt_hold("fault_halt", 1'b1);
        do_reset();
        return;
      end
    end else begin
      mem_ack = 1'($urandom);
      step_chk("exec_nomem", 8'h00);
    end
    zero_flag = zf < 0 ? 1'($urandom) : 1'(zf);
    carry_flag = cf < 0 ? 1'($urandom) : 1'(cf);
    take = op == 5 || (op == 6 && zero_flag) || (op == 7 && carry_flag);
    mem_ack = 1'($urandom);
    step_chk("pc_upd", {4'b0, !take, take, 2'b0});
  endtask
  task automatic sta_reset();
    bit to;
    opcode = 4'd2;
    mem_phase("sta_fetch", 1'b0, 1'b1, 2'b00, 0, to);
    step_chk("sta_decode", 8'h00);
    mem_ack = 1'b0;
    step_chk("sta_wait", 8'b1100_0000);
    reset_n = 1'b0;
    #1;
    chk("sta_reset_now", 32'(outs()), 32'h0);
    @(posedge clk);
    #1;
    do_reset();
    run_instr(0, 0, 0, -1, -1);
  endtask
  initial begin
    int s_cyc, s_pce, op, fw, ew;
    do_reset();
    s_cyc = cyc;
    s_pce = npce;
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, -1, -1);
    chk("nop_cycles", 32'(cyc - s_cyc), 32'd12);
    chk("nop_pc_en", 32'(npce - s_pce), 32'd3);
    run_instr(3, 0, 2, -1, -1);
    run_instr(6, 0, 0, 1, -1);
    run_instr(6, 1, 0, 0, -1);
    run_instr(7, 0, 0, -1, 1);
    run_instr(5, 0, 0, 0, 0);
    run_instr(1, 14, 14, -1, -1);
    run_instr(3, 0, 15, -1, -1);
    run_instr(0, 16, 0, -1, -1);
    sta_reset();
    run_instr(15, 0, 0, -1, -1);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 15);
      fw = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 3);
      ew = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 3);
      run_instr(op, fw, ew, -1, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
